sc_stream_decoder: RTL and testbench



---
 rtl/sc_pkg.sv | 16 +
 rtl/sc_window_counter.sv | 50 +++++
 rtl/sc_stream_decoder.sv | 108 ++++++++++
 tb/tb_sc_stream_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing stream back end.
// FSM state encoding and window-length helper used by the decoder slice.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // Window length N for a given log2 size.
    function automatic int unsigned win_len(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Ones / valid-bit counters for one decoding window.
// Clear has priority over enable; last flags the (N-1)-th count.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH:0]   ones,
    output logic             last
);

    localparam int unsigned N = win_len(WIDTH);
    localparam logic [WIDTH:0] LAST_CNT = (WIDTH+1)'(N - 1);

    logic [WIDTH:0] cnt_q, cnt_d;
    logic [WIDTH:0] ones_q, ones_d;

    // Next counter values: clear wins, otherwise count accepted bits.
    always_comb begin
        cnt_d  = cnt_q;
        ones_d = ones_q;
        if (clr) begin
            cnt_d  = '0;
            ones_d = '0;
        end else if (en) begin
            cnt_d  = cnt_q + 1'b1;
            ones_d = ones_q + {{WIDTH{1'b0}}, bit_in};
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

    assign ones = ones_q;
    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2**WIDTH valid bits
// and emits a unipolar or bipolar binary estimate with a 1-cycle pulse.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit BIPOLAR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH+1:0] result,
    output logic             result_valid
);

    localparam logic [WIDTH+1:0] N_EXT = {2'b01, {WIDTH{1'b0}}};

    fsm_state_t       state_q, state_d;
    logic [WIDTH+1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH:0]   ones;
    logic             last;
    logic [WIDTH:0]   ones_fin;
    logic [WIDTH+1:0] scaled;

    sc_window_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .bit_in (bit_in),
        .ones   (ones),
        .last   (last)
    );

    // Final estimate including the bit accepted on the closing edge.
    always_comb begin
        ones_fin = ones + {{WIDTH{1'b0}}, bit_in};
        if (BIPOLAR)
            scaled = {ones_fin, 1'b0} - N_EXT;
        else
            scaled = {1'b0, ones_fin};
    end

    // Next state, counter control and output register inputs.
    always_comb begin
        state_d        = state_q;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (start) begin
                    cnt_clr = 1'b1;
                end else if (bit_valid) begin
                    cnt_en = 1'b1;
                    if (last) begin
                        state_d        = DONE;
                        result_d       = scaled;
                        result_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench: bipolar and unipolar decoders share one stimulus
// stream; expected results are queued and checked by a monitor.
module tb_sc_stream_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       busy_b, busy_u;
    logic [5:0] result_b, result_u;
    logic       rv_b, rv_u;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct {
        logic [5:0] b;
        logic [5:0] u;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sc_stream_decoder #(.WIDTH(4), .BIPOLAR(1'b1)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .busy         (busy_b),
        .result       (result_b),
        .result_valid (rv_b)
    );

    sc_stream_decoder #(.WIDTH(4), .BIPOLAR(1'b0)) dut_u (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .busy         (busy_u),
        .result       (result_u),
        .result_valid (rv_u)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per observed result pulse.
    always @(negedge clk) begin
        if (!reset && (rv_b || rv_u)) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_pulse: rv_b=%0b rv_u=%0b cyc=%0d",
                         rv_b, rv_u, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rv_bipolar", int'(rv_b), 1);
                chk("rv_unipolar", int'(rv_u), 1);
                chk("result_bipolar", int'($signed(result_b)), int'($signed(e.b)));
                chk("result_unipolar", int'(result_u), int'(e.u));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_bit);
        start     = 1'b1;
        bit_in    = with_bit;
        bit_valid = with_bit;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic feed_bits(input logic [15:0] bits, input bit gaps);
        int   ones;
        exp_t e;
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(bits[i]);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    tick();
                end
            end
            bit_in    = bits[i];
            bit_valid = 1'b1;
            if (i == 15) begin
                e.b   = 6'(2 * ones - 16);
                e.u   = 6'(ones);
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tick();
        tick();
        chk("reset_busy", int'(busy_b), 0);
        chk("reset_result", int'(result_b), 0);
        chk("reset_rv", int'(rv_b), 0);
        reset = 1'b0;
        idle(2);

        // 1: all ones -> +16 / 16
        pulse_start(1'b0);
        chk("busy_count", int'(busy_b), 1);
        feed_bits(16'hFFFF, 1'b0);
        chk("busy_done", int'(busy_b), 1);
        tick();
        chk("idle_after_done", int'(busy_b), 0);
        idle(2);

        // 2: all zeros -> -16 / 0, alternating -> 0 / 8
        pulse_start(1'b0);
        feed_bits(16'h0000, 1'b0);
        idle(3);
        pulse_start(1'b0);
        feed_bits(16'hAAAA, 1'b0);
        idle(3);
        chk("result_hold", int'($signed(result_b)), 0);

        // 3: 12 ones with random stalls -> +8 / 12
        pulse_start(1'b0);
        feed_bits(16'hF0FF, 1'b1);
        idle(3);

        // 4: abort after 10 bits, start coincides with a valid bit
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        pulse_start(1'b1);
        feed_bits(16'hFFFF, 1'b0);
        idle(3);

        // 5: async reset at bit 7, bits then ignored while idle
        pulse_start(1'b0);
        for (int i = 0; i < 7; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", int'(busy_b), 0);
        chk("midreset_result", int'(result_b), 0);
        chk("midreset_result_u", int'(result_u), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk("idle_ignores_bits", int'(busy_b), 0);
        idle(2);

        // 6: start in DONE chains windows; saturated stream settles at +16
        pulse_start(1'b0);
        feed_bits(16'hAAAA, 1'b0);
        pulse_start(1'b0);
        chk("chain_busy", int'(busy_b), 1);
        feed_bits(16'hFFFE, 1'b0);
        pulse_start(1'b0);
        feed_bits(16'hFFFF, 1'b0);
        pulse_start(1'b0);
        feed_bits(16'hFFFF, 1'b0);
        idle(4);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
